// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// ram_arbiter_if: requester-side and RAM-side signal bundle for ram_arbiter
// Revision: 1.0
// ============================================================================
interface ram_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_store;
   logic [31:0] ram_load;
   logic [1:0]  ram_state;
   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_state,
      output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_state,
      input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store, err
   );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter: shares one RAM port between instruction fetch and data access
// Build option RAM_ARB_FAIR_EN: alternate priority on simultaneous requests
// Revision: 1.0
// ============================================================================
module ram_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic         CLK,
   input  logic         nRST,
   ram_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] DGRANT     = 2'd1;
   localparam logic [1:0] IGRANT     = 2'd2;
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

   logic [1:0]  state, next_state;
   logic [7:0]  cnt, next_cnt;
   logic        dreq, data_pri, granted, req_g, hit, fault, expire, finish;
   logic        iwait, dwait, ram_ren, ram_wen, err;
   logic [31:0] iload, dload, ram_addr, ram_store;

`ifdef RAM_ARB_FAIR_EN
   logic last_d;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         last_d <= 1'b0;
      else if (state == IDLE && next_state != IDLE)
         last_d <= (next_state == DGRANT);
   end

   assign data_pri = ~last_d;
`else
   assign data_pri = 1'b1;
`endif

   assign dreq    = bus.dREN | bus.dWEN;
   assign granted = (state == DGRANT) | (state == IGRANT);
   assign req_g   = (state == DGRANT) ? dreq : bus.iREN;
   assign hit     = granted & req_g & (bus.ram_state == RAM_ACCESS);
   assign fault   = granted & req_g & (bus.ram_state == RAM_ERROR);
   // RAM completion in the final allowed cycle takes precedence over the abort
   assign expire  = granted & req_g & ~hit & ~fault & (cnt == CNT_LAST);
   assign finish  = hit | fault | expire;
   assign err     = fault | expire;

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         IDLE: begin
            next_cnt = '0;
            if (dreq && (!bus.iREN || data_pri))
               next_state = DGRANT;
            else if (bus.iREN)
               next_state = IGRANT;
         end
         DGRANT, IGRANT: begin
            if (!req_g || finish)
               next_state = IDLE;
            else
               next_cnt = cnt + 8'd1;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_store = '0;
      iwait     = bus.iREN;
      dwait     = dreq;
      iload     = '0;
      dload     = '0;
      case (state)
         DGRANT: begin
            ram_addr  = bus.daddr;
            ram_store = bus.dstore;
            ram_wen   = bus.dWEN;
            ram_ren   = bus.dREN & ~bus.dWEN;
            if (finish)
               dwait = 1'b0;
            if (hit)
               dload = bus.ram_load;
         end
         IGRANT: begin
            ram_addr = bus.iaddr;
            ram_ren  = 1'b1;
            if (finish)
               iwait = 1'b0;
            if (hit)
               iload = bus.ram_load;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   assign bus.iwait     = iwait;
   assign bus.iload     = iload;
   assign bus.dwait     = dwait;
   assign bus.dload     = dload;
   assign bus.ram_ren   = ram_ren;
   assign bus.ram_wen   = ram_wen;
   assign bus.ram_addr  = ram_addr;
   assign bus.ram_store = ram_store;
   assign bus.err       = err;
endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles one grant waits for RAM completion before abort (range 1..255).
REQ-002 SHALL have CLK  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have iREN  input  1  instruction fetch request; iaddr  input  32  fetch address.
REQ-005 SHALL have iwait  output  1  fetch not yet complete; iload  output  32  fetched word.
REQ-006 SHALL have dREN  input  1  data read request; dWEN  input  1  data write request; daddr  input  32  data address; dstore  input  32  write data.
REQ-007 SHALL have dwait  output  1  data access not yet complete; dload  output  32  read word.
REQ-008 SHALL have ram_ren  output  1, ram_wen  output  1, ram_addr  output  32, ram_store  output  32, all driving the single RAM port.
REQ-009 SHALL have ram_load  input  32  RAM read word; ram_state  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-010 SHALL have err  output  1  one-cycle pulse on RAM ERROR or timeout abort.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, DGRANT, IGRANT, with state registered.
REQ-012 In IDLE, SHALL go to DGRANT next cycle if dREN|dWEN, else to IGRANT if iREN, else stay in IDLE.
REQ-013 When both sides request in IDLE, SHALL grant data (overridden only per REQ-027).
REQ-014 In IDLE, SHALL drive ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0.
REQ-015 In DGRANT, SHALL drive ram_addr=daddr, ram_store=dstore, ram_wen=dWEN, ram_ren=dREN&~dWEN; write wins when both are high.
REQ-016 In IGRANT, SHALL drive ram_addr=iaddr, ram_ren=1, ram_wen=0, ram_store=0.
REQ-017 SHALL treat ram_state==ACCESS during a grant as completion: the granted wait output is 0 that same cycle, load output = ram_load combinationally, and the FSM returns to IDLE next cycle.
REQ-018 SHALL drive iwait=iREN and dwait=dREN|dWEN in every cycle not covered by REQ-017 and REQ-020.
REQ-019 SHALL drive the load output of the non-granted side to 0; the granted side's load is 0 except in its completion cycle.
REQ-020 On ram_state==ERROR during a grant, SHALL complete per REQ-017 with load=0 and pulse err for one cycle.
REQ-021 SHALL keep an 8-bit grant cycle counter, cleared on entry to a grant and incremented each grant cycle without completion.
REQ-022 When the counter reaches TIMEOUT, SHALL abort: deassert the granted wait that cycle, load=0, pulse err, and return to IDLE.
REQ-023 If the granted requester drops its request mid-grant, SHALL return to IDLE next cycle with no completion and no err.
REQ-024 SHALL require at least one IDLE cycle between consecutive grants; minimum transaction latency is 2 cycles (request to wait low).
REQ-025 SHALL never assert ram_ren and ram_wen simultaneously.

Reset
REQ-026 On nRST low, SHALL immediately force state=IDLE, counter=0, err=0, ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0, iload=0, dload=0; a grant in progress is abandoned and the requester keeps waiting.

Configuration
REQ-027 With macro RAM_ARB_FAIR_EN defined, SHALL hold a last-granted flag (reset to instruction) and, on simultaneous requests in IDLE, grant the side not granted last. Without it, data always wins per REQ-013 and the flag is not built.

Verification
REQ-028 iREN=1, iaddr=0x40, ram_state=BUSY 3 cycles then ACCESS with ram_load=0x8C010004 -> ram_ren=1, ram_addr=0x40; iwait low and iload=0x8C010004 in the ACCESS cycle, then IDLE.
REQ-029 iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) both held -> DGRANT first with ram_wen=1; after completion, one IDLE cycle, then IGRANT. With RAM_ARB_FAIR_EN, a second simultaneous request grants instruction.
REQ-030 dREN=1, ram_state held BUSY, TIMEOUT=4 -> dwait low with dload=0 and err high in the 4th grant cycle, then IDLE.
REQ-031 dREN=1, ram_state=ERROR on the 2nd grant cycle -> dwait=0, dload=0, err pulse for 1 cycle.
REQ-032 nRST asserted mid-IGRANT -> ram_ren=0, state=IDLE at once; after release, a held iREN is re-granted 1 cycle later.
